alu_sequencer: RTL

Requester-side controller for the multi-cycle ALU. Accepts one decoded operation at a time from the control unit over a valid/ready handshake and drives the ALU's `en`/`alu_control`/operand inputs. It waits for the ALU's registered completion, then presents the result, HI/LO, overflow and zero flags to the register-file/HI-LO writeback over a second valid/ready handshake. Sits between the decode/control FSM and the ALU datapath.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and sequencer state encoding.
// Used by the ALU, the decoder and alu_sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_NOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_MULT = 4'd8,
    ALU_DIV  = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Requester-side controller between decode/control and the multi-cycle ALU.
// Optional WAIT timeout is built when ALU_SEQ_TIMEOUT_EN is defined.
module alu_sequencer
  import alu_pkg::*;
`ifdef ALU_SEQ_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_dest,
  output logic        alu_en,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [31:0] wb_data_hi,
  output logic        wb_hilo,
  output logic        wb_overflow,
  output logic        wb_zero,
  output logic        wb_err
);

  seq_state_e  state_q, state_d;

  logic [3:0]  ctrl_q;
  logic [31:0] srca_q;
  logic [31:0] srcb_q;
  logic [4:0]  dest_q;
  logic [31:0] data_q;
  logic [31:0] hi_q;
  logic        hilo_q;
  logic        ovf_q;
  logic        zero_q;
  logic        err_q;

  logic        accept;
  logic        legal;
  logic        capture;
  logic        tmo;
  logic        tmo_fire;

  assign legal    = (op_code <= ALU_OP_LAST);
  assign accept   = op_valid && (state_q == S_IDLE);
  assign capture  = (state_q == S_WAIT) && alu_done;
  assign tmo_fire = (state_q == S_WAIT) && !alu_done && tmo;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tmo   = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (state_q == S_WAIT) ? cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) state_d = legal ? S_ISSUE : S_RESP;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_done || tmo) state_d = S_RESP;
      end
      S_RESP: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // op_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    op_ready = rst_n && (state_q == S_IDLE);
    alu_en   = (state_q == S_ISSUE);
    wb_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      srca_q <= '0;
      srcb_q <= '0;
      dest_q <= '0;
      data_q <= '0;
      hi_q   <= '0;
      hilo_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      ctrl_q <= op_code;
      srca_q <= op_a;
      srcb_q <= op_b;
      dest_q <= op_dest;
      data_q <= '0;
      hi_q   <= '0;
      hilo_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= !legal;
    end else if (capture) begin
      hilo_q <= is_hilo_op(ctrl_q);
      data_q <= is_hilo_op(ctrl_q) ? alu_lo : alu_result;
      hi_q   <= is_hilo_op(ctrl_q) ? alu_hi : '0;
      ovf_q  <= alu_overflow;
      zero_q <= alu_zero;
      err_q  <= 1'b0;
    end else if (tmo_fire) begin
      err_q  <= 1'b1;
    end
  end

  assign alu_control = ctrl_q;
  assign alu_srcA    = srca_q;
  assign alu_srcB    = srcb_q;
  assign wb_dest     = dest_q;
  assign wb_data     = data_q;
  assign wb_data_hi  = hi_q;
  assign wb_hilo     = hilo_q;
  assign wb_overflow = ovf_q;
  assign wb_zero     = zero_q;
  assign wb_err      = err_q;

endmodule
